// File: rtl/uart_frame_loader.sv
// UART byte stream -> framed pixel writes (sync, slot, payload) through a 2-entry write queue.
// Optional trailing checksum byte when UART_FRAME_LOADER_CHECKSUM_EN is defined.
module uart_frame_loader #(
  parameter int                DATA_W        = 16,
  parameter int                BYTES_PER_PIX = 1,
  parameter int                FRAME_PIXELS  = 307200,
  parameter int                NUM_FRAMES    = 5,
  parameter int                ADDR_W        = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [7:0]        SYNC_BYTE     = 8'hA5,
  parameter int                TIMEOUT_CYC   = 20000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [7:0]        iRX_DATA,
  input  logic              iRX_VALID,
  output logic [DATA_W-1:0] oWR_DATA,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oWR_VALID,
  input  logic              iWR_READY,
  output logic              oBUSY,
  output logic [7:0]        oSLOT,
  output logic              oDONE,
  output logic              oERR,
  output logic [1:0]        oERR_CODE,
  output logic              oOVERRUN,
  output logic [7:0]        oFRAME_CNT
);

  localparam int PIX_W  = 8 * BYTES_PER_PIX;
  localparam int PIDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int BIDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SLOT,
    S_PAYLOAD
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t              state;
  logic [PIDX_W-1:0]   pix_idx;
  logic [BIDX_W-1:0]   byte_idx;
  logic [TMR_W-1:0]    timer;
  logic [ADDR_W-1:0]   slot_base;
  logic [PIX_W-1:0]    pix_next;
  logic                byte_last;
  logic                pix_last;
  logic                slot_ok;
  logic                expire;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic                push_vld_p0;
  logic [DATA_W-1:0]   push_data_p0;
  logic [ADDR_W-1:0]   push_addr_p0;

  logic [DATA_W-1:0]   q_data [2];
  logic [ADDR_W-1:0]   q_addr [2];
  logic                q_wptr;
  logic                q_rptr;
  logic [1:0]          q_cnt;
  logic                q_pop;
  logic                q_push;

  // Slot base wraps modulo 2^ADDR_W, so truncating operands before the multiply is exact.
  function automatic logic [ADDR_W-1:0] slot_base_addr(input logic [7:0] slot);
    return BASE_ADDR + ADDR_W'(slot) * ADDR_W'(FRAME_PIXELS);
  endfunction

  function automatic logic [DATA_W-1:0] zext_pixel(input logic [PIX_W-1:0] pix);
    return DATA_W'(pix);
  endfunction

  if (BYTES_PER_PIX == 1) begin : g_one_byte
    assign pix_next = iRX_DATA;
  end else begin : g_multi_byte
    logic [PIX_W-9:0] pix_acc;
    // Earlier bytes sit in the upper part; the partial pixel is discarded via byte_idx on abort.
    always_ff @(posedge iCLK) begin
      if (iRX_VALID && state == S_PAYLOAD) pix_acc <= pix_next[PIX_W-9:0];
    end
    assign pix_next = {pix_acc, iRX_DATA};
  end

  assign byte_last = (byte_idx == BIDX_W'(BYTES_PER_PIX - 1));
  assign pix_last  = (pix_idx == PIDX_W'(FRAME_PIXELS - 1));
  assign slot_ok   = ({24'd0, iRX_DATA} < 32'(NUM_FRAMES));
  assign expire    = (state != S_IDLE) && !iRX_VALID && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign oBUSY     = (state != S_IDLE);

  always_ff @(posedge iCLK) begin
    if (iRX_VALID && state == S_SLOT) slot_base <= slot_base_addr(iRX_DATA);
  end

  always_ff @(posedge iCLK) begin
    oDONE <= 1'b0;
    oERR  <= 1'b0;
    if (iRST) begin
      state      <= S_IDLE;
      pix_idx    <= '0;
      byte_idx   <= '0;
      timer      <= '0;
      oSLOT      <= 8'd0;
      oERR_CODE  <= 2'd0;
      oFRAME_CNT <= 8'd0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      if (iRX_VALID || state == S_IDLE) timer <= '0;
      else                              timer <= timer + TMR_W'(1);

      if (expire) begin
        oERR      <= 1'b1;
        oERR_CODE <= 2'd2;
        byte_idx  <= '0;
        state     <= S_IDLE;
      end else if (iRX_VALID) begin
        case (state)
          S_IDLE: begin
            if (iRX_DATA == SYNC_BYTE) state <= S_SLOT;
          end
          S_SLOT: begin
            if (slot_ok) begin
              oSLOT    <= iRX_DATA;
              pix_idx  <= '0;
              byte_idx <= '0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
              csum     <= 8'd0;
`endif
              state    <= S_PAYLOAD;
            end else begin
              oERR      <= 1'b1;
              oERR_CODE <= 2'd1;
              state     <= S_IDLE;
            end
          end
          S_PAYLOAD: begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            csum <= csum + iRX_DATA;
`endif
            if (byte_last) begin
              byte_idx <= '0;
              if (pix_last) begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                state <= S_CHECK;
`else
                oDONE      <= 1'b1;
                oFRAME_CNT <= oFRAME_CNT + 8'd1;
                state      <= S_IDLE;
`endif
              end else begin
                pix_idx <= pix_idx + PIDX_W'(1);
              end
            end else begin
              byte_idx <= byte_idx + BIDX_W'(1);
            end
          end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (iRX_DATA == csum) begin
              oDONE      <= 1'b1;
              oFRAME_CNT <= oFRAME_CNT + 8'd1;
            end else begin
              oERR      <= 1'b1;
              oERR_CODE <= 2'd3;
            end
            state <= S_IDLE;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage p0: completed pixel presented to the queue in the cycle its last byte arrives.
  assign push_vld_p0  = iRX_VALID && (state == S_PAYLOAD) && byte_last;
  assign push_data_p0 = zext_pixel(pix_next);
  assign push_addr_p0 = slot_base + ADDR_W'(pix_idx);

  assign q_pop  = (q_cnt != 2'd0) && iWR_READY;
  assign q_push = push_vld_p0 && ((q_cnt != 2'd2) || q_pop);

  // Queue storage is cleared on reset so the write outputs read zero.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      q_wptr   <= 1'b0;
      q_rptr   <= 1'b0;
      q_cnt    <= 2'd0;
      oOVERRUN <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      if (q_push) begin
        q_data[q_wptr] <= push_data_p0;
        q_addr[q_wptr] <= push_addr_p0;
        q_wptr         <= ~q_wptr;
      end
      if (q_pop) q_rptr <= ~q_rptr;
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
      if (push_vld_p0 && !q_push) oOVERRUN <= 1'b1;
    end
  end

  assign oWR_VALID = (q_cnt != 2'd0);
  assign oWR_DATA  = q_data[q_rptr];
  assign oWR_ADDR  = q_addr[q_rptr];

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: dut1 uses 1 byte/pixel, dut2 uses 2 bytes/pixel.
module tb_uart_frame_loader;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid1, rx_valid2;
  logic        ready1, ready2;

  logic [15:0] wr_data1, wr_data2;
  logic [22:0] wr_addr1, wr_addr2;
  logic        wr_valid1, wr_valid2, busy1, busy2, done1, done2, err1, err2, ovr1, ovr2;
  logic [7:0]  slot1, slot2, fcnt1, fcnt2;
  logic [1:0]  code1, code2;

  always #5 clk = ~clk;

  uart_frame_loader #(.DATA_W(16), .BYTES_PER_PIX(1), .FRAME_PIXELS(4), .NUM_FRAMES(5),
    .ADDR_W(23), .BASE_ADDR(23'h000000), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut1 (
    .iCLK(clk), .iRST(rst), .iRX_DATA(rx_data), .iRX_VALID(rx_valid1),
    .oWR_DATA(wr_data1), .oWR_ADDR(wr_addr1), .oWR_VALID(wr_valid1), .iWR_READY(ready1),
    .oBUSY(busy1), .oSLOT(slot1), .oDONE(done1), .oERR(err1), .oERR_CODE(code1),
    .oOVERRUN(ovr1), .oFRAME_CNT(fcnt1));

  uart_frame_loader #(.DATA_W(16), .BYTES_PER_PIX(2), .FRAME_PIXELS(2), .NUM_FRAMES(5),
    .ADDR_W(23), .BASE_ADDR(23'h000000), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut2 (
    .iCLK(clk), .iRST(rst), .iRX_DATA(rx_data), .iRX_VALID(rx_valid2),
    .oWR_DATA(wr_data2), .oWR_ADDR(wr_addr2), .oWR_VALID(wr_valid2), .iWR_READY(ready2),
    .oBUSY(busy2), .oSLOT(slot2), .oDONE(done2), .oERR(err2), .oERR_CODE(code2),
    .oOVERRUN(ovr2), .oFRAME_CNT(fcnt2));

  typedef struct {
    logic [22:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  slot;
    logic [31:0] pay;
    logic        ok;
  } vec_t;

  wr_t  wq1[$];
  wr_t  wq2[$];
  int   done_cnt1 = 0, done_cnt2 = 0, err_cnt1 = 0, err_cnt2 = 0, both_cnt = 0;
  int   errors = 0, checks = 0;
  int   exp_cnt1 = 0;
  logic [7:0] last_csum;

  always @(negedge clk) begin
    if (wr_valid1 && ready1) wq1.push_back('{addr: wr_addr1, data: wr_data1});
    if (wr_valid2 && ready2) wq2.push_back('{addr: wr_addr2, data: wr_data2});
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
    if (err1) err_cnt1++;
    if (err2) err_cnt2++;
    if ((done1 && err1) || (done2 && err2)) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send1(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid1 = 1'b1;
    @(posedge clk); #1;
    rx_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid2 = 1'b1;
    @(posedge clk); #1;
    rx_valid2 = 1'b0;
  endtask

  task automatic csum1(input logic [7:0] s);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    send1(s);
`else
    last_csum = s;
`endif
  endtask

  task automatic csum2(input logic [7:0] s);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    send2(s);
`else
    last_csum = s;
`endif
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_wr_valid"}, wr_valid1, 0);
    chk({tag, "_wr_data"}, wr_data1, 0);
    chk({tag, "_wr_addr"}, wr_addr1, 0);
    chk({tag, "_ctrl"}, {busy1, done1, err1, code1, ovr1}, 0);
    chk({tag, "_slot"}, slot1, 0);
    chk({tag, "_fcnt"}, fcnt1, 0);
  endtask

  task automatic chk_wq1(input string tag, input int idx, input logic [22:0] a, input logic [15:0] d);
    if (idx < wq1.size()) begin
      chk($sformatf("%s_addr%0d", tag, idx), wq1[idx].addr, a);
      chk($sformatf("%s_data%0d", tag, idx), wq1[idx].data, d);
    end
  endtask

  task automatic chk_wq2(input string tag, input int idx, input logic [22:0] a, input logic [15:0] d);
    if (idx < wq2.size()) begin
      chk($sformatf("%s_addr%0d", tag, idx), wq2[idx].addr, a);
      chk($sformatf("%s_data%0d", tag, idx), wq2[idx].data, d);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int d0, e0, hit;
    logic [7:0] b, sum;

    vt[0] = '{slot: 8'h02, pay: 32'h11223344, ok: 1'b1};
    vt[1] = '{slot: 8'h00, pay: 32'hA500FF01, ok: 1'b1};
    vt[2] = '{slot: 8'h05, pay: 32'h0, ok: 1'b0};
    vt[3] = '{slot: 8'h04, pay: 32'h807F01FE, ok: 1'b1};
    vt[4] = '{slot: 8'hFF, pay: 32'h0, ok: 1'b0};
    vt[5] = '{slot: 8'h01, pay: 32'h5A5A5A5A, ok: 1'b1};

    rst = 1'b1; rx_data = 8'h00; rx_valid1 = 1'b0; rx_valid2 = 1'b0;
    ready1 = 1'b1; ready2 = 1'b1; last_csum = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero1("reset");
    chk("reset_dut2", {wr_valid2, busy2, done2, err2, code2, ovr2, slot2, fcnt2}, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt1; e0 = err_cnt1; wq1.delete();
      send1(8'hA5);
      send1(vt[v].slot);
      if (vt[v].ok) begin
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
          b = vt[v].pay[31-8*i -: 8];
          sum = sum + b;
          send1(b);
        end
        csum1(sum);
      end
      repeat (6) @(posedge clk);
      #1;
      if (vt[v].ok) begin
        exp_cnt1++;
        chk($sformatf("v%0d_done", v), done_cnt1 - d0, 1);
        chk($sformatf("v%0d_err", v), err_cnt1 - e0, 0);
        chk($sformatf("v%0d_fcnt", v), fcnt1, 8'(exp_cnt1));
        chk($sformatf("v%0d_slot", v), slot1, vt[v].slot);
        chk($sformatf("v%0d_nwr", v), wq1.size(), 4);
        for (int i = 0; i < 4; i++)
          chk_wq1($sformatf("v%0d", v), i, 23'(vt[v].slot * 4 + i), {8'h00, vt[v].pay[31-8*i -: 8]});
      end else begin
        chk($sformatf("v%0d_err", v), err_cnt1 - e0, 1);
        chk($sformatf("v%0d_code", v), code1, 1);
        chk($sformatf("v%0d_done", v), done_cnt1 - d0, 0);
        chk($sformatf("v%0d_nwr", v), wq1.size(), 0);
        chk($sformatf("v%0d_busy", v), busy1, 0);
      end
    end

    // Two bytes per pixel: write appears one cycle after each pixel's second byte.
    d0 = done_cnt2; wq2.delete();
    send2(8'hA5); send2(8'h00); send2(8'h12);
    chk("bpp2_valid_early", wr_valid2, 0);
    send2(8'h34);
    chk("bpp2_valid_p0", wr_valid2, 1);
    chk("bpp2_data_p0", wr_data2, 16'h1234);
    chk("bpp2_addr_p0", wr_addr2, 0);
    send2(8'h56); send2(8'h78);
    chk("bpp2_valid_p1", wr_valid2, 1);
    chk("bpp2_data_p1", wr_data2, 16'h5678);
    chk("bpp2_addr_p1", wr_addr2, 1);
    csum2(8'h14);
    repeat (4) @(posedge clk);
    #1;
    chk("bpp2_done", done_cnt2 - d0, 1);
    chk("bpp2_fcnt", fcnt2, 1);
    chk("bpp2_nwr", wq2.size(), 2);

    // Partial pixel discarded on timeout; next packet pairs bytes from scratch.
    e0 = err_cnt2;
    send2(8'hA5); send2(8'h00); send2(8'hAB);
    repeat (TMO + 4) @(posedge clk);
    #1;
    chk("bpp2_tmo_err", err_cnt2 - e0, 1);
    chk("bpp2_tmo_code", code2, 2);
    wq2.delete();
    send2(8'hA5); send2(8'h01); send2(8'hCD); send2(8'hEF); send2(8'h01); send2(8'h02);
    csum2(8'hBF);
    repeat (6) @(posedge clk);
    #1;
    chk("bpp2_after_nwr", wq2.size(), 2);
    chk_wq2("bpp2_after", 0, 23'd2, 16'hCDEF);
    chk_wq2("bpp2_after", 1, 23'd3, 16'h0102);

    // Byte arriving on the expiry cycle wins and the packet completes.
    d0 = done_cnt1; e0 = err_cnt1;
    send1(8'hA5); send1(8'h01);
    repeat (TMO - 2) @(posedge clk);
    send1(8'h21);
    send1(8'h22); send1(8'h23); send1(8'h24);
    csum1(8'h8A);
    repeat (6) @(posedge clk);
    #1;
    exp_cnt1++;
    chk("tmo_edge_err", err_cnt1 - e0, 0);
    chk("tmo_edge_done", done_cnt1 - d0, 1);
    chk("tmo_edge_fcnt", fcnt1, 8'(exp_cnt1));

    // Real timeout: error exactly TMO cycles after the last byte; queued pixel still drains.
    wq1.delete();
    send1(8'hA5); send1(8'h01); send1(8'h11);
    hit = 0;
    for (int c = 1; c <= 3 * TMO; c++) begin
      @(posedge clk); #1;
      if (err1) begin
        hit = c;
        break;
      end
    end
    chk("tmo_latency", hit, TMO);
    chk("tmo_code", code1, 2);
    chk("tmo_busy", busy1, 0);
    chk("tmo_nwr", wq1.size(), 1);
    chk_wq1("tmo", 0, 23'd4, 16'h0011);

    // Push while full coinciding with a pop: nothing dropped.
    wq1.delete(); d0 = done_cnt1;
    ready1 = 1'b0;
    send1(8'hA5); send1(8'h03); send1(8'h11); send1(8'h22);
    @(posedge clk); #1;
    rx_data = 8'h33; rx_valid1 = 1'b1; ready1 = 1'b1;
    @(posedge clk); #1;
    rx_valid1 = 1'b0;
    send1(8'h44);
    csum1(8'hAA);
    repeat (6) @(posedge clk);
    #1;
    exp_cnt1++;
    chk("pushpop_nwr", wq1.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_wq1("pushpop", i, 23'(12 + i), 16'(8'h11 * (i + 1)));
    chk("pushpop_ovr", ovr1, 0);
    chk("pushpop_done", done_cnt1 - d0, 1);

    // Overrun: third and fourth pixels dropped, exactly two drain.
    wq1.delete(); d0 = done_cnt1;
    ready1 = 1'b0;
    send1(8'hA5); send1(8'h03); send1(8'h51); send1(8'h52); send1(8'h53);
    chk("ovr_flag", ovr1, 1);
    chk("ovr_valid", wr_valid1, 1);
    chk("ovr_head_data", wr_data1, 16'h0051);
    chk("ovr_head_addr", wr_addr1, 12);
    send1(8'h54);
    csum1(8'h4A);
    repeat (3) @(posedge clk);
    #1;
    ready1 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    exp_cnt1++;
    chk("ovr_nwr", wq1.size(), 2);
    chk_wq1("ovr", 0, 23'd12, 16'h0051);
    chk_wq1("ovr", 1, 23'd13, 16'h0052);
    chk("ovr_sticky", ovr1, 1);
    chk("ovr_done", done_cnt1 - d0, 1);
    chk("ovr_fcnt", fcnt1, 8'(exp_cnt1));

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
    d0 = done_cnt1; e0 = err_cnt1; wq1.delete();
    send1(8'hA5); send1(8'h00); send1(8'h10); send1(8'h20); send1(8'h30); send1(8'h40); send1(8'hA0);
    repeat (4) @(posedge clk);
    #1;
    exp_cnt1++;
    chk("csum_good_done", done_cnt1 - d0, 1);
    chk("csum_good_err", err_cnt1 - e0, 0);
    chk("csum_good_fcnt", fcnt1, 8'(exp_cnt1));
    d0 = done_cnt1; e0 = err_cnt1; wq1.delete();
    send1(8'hA5); send1(8'h00); send1(8'h10); send1(8'h20); send1(8'h30); send1(8'h40); send1(8'hA1);
    repeat (4) @(posedge clk);
    #1;
    chk("csum_bad_err", err_cnt1 - e0, 1);
    chk("csum_bad_code", code1, 3);
    chk("csum_bad_done", done_cnt1 - d0, 0);
    chk("csum_bad_nwr", wq1.size(), 4);
    chk("csum_bad_fcnt", fcnt1, 8'(exp_cnt1));
`endif

    // Reset in the middle of a payload clears every output.
    send1(8'hA5); send1(8'h02); send1(8'h11);
    chk("pre_rst_busy", busy1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero1("midrst");

    chk("done_err_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
